// File: rtl/preamble_gen_if.sv
// Purpose: AXI-Stream bundle carrying packed I/Q preamble samples.
// Latency: none, wires only.
// Backpressure: tready from the slave holds the master's current beat.
// Ports: tvalid/tlast/tdata driven by the master, tready driven by the slave.
interface preamble_gen_if;
    logic        tvalid;
    logic        tlast;
    logic [31:0] tdata;   // {I[31:16], Q[15:0]}, signed Q1.15
    logic        tready;

    modport master (output tvalid, tlast, tdata, input tready);
    modport slave  (input tvalid, tlast, tdata, output tready);
endinterface

// File: rtl/preamble_gen.sv
// Purpose: 802.11a/g legacy training sequence (10 STS, GI2, 2 LTS = 320 samples) plus optional zero gap.
// Latency: start_in/continuous_in sampled in IDLE -> first sample valid on the next cycle; registered outputs.
// Backpressure: tdata/tlast/tvalid hold while tvalid & ~tready; one sample per cycle when tready stays high.
// Ports: clk_in, rst_in (sync, active high), start_in (pulse), continuous_in (level),
//        preamble_axis (AXI-Stream master), busy_out (not IDLE), frame_cnt_out (completed frames, wraps).
module preamble_gen #(
    parameter int unsigned GAP_SAMPLES = 400,
    parameter int unsigned AMP_SHIFT   = 0
) (
    input  logic           clk_in,
    input  logic           rst_in,
    input  logic           start_in,
    input  logic           continuous_in,
    preamble_gen_if.master preamble_axis,
    output logic           busy_out,
    output logic [15:0]    frame_cnt_out
);

    // Nine bits cover the 160-sample STS run; widen only if the gap is longer than 512.
    localparam int unsigned IDX_W = (GAP_SAMPLES > 512) ? $clog2(GAP_SAMPLES) : 9;

    localparam logic [IDX_W-1:0] STS_LAST = IDX_W'(159);
    localparam logic [IDX_W-1:0] GI_LAST  = IDX_W'(31);
    localparam logic [IDX_W-1:0] LTS_LAST = IDX_W'(63);
    localparam logic [IDX_W-1:0] GAP_LAST = IDX_W'((GAP_SAMPLES == 0) ? 0 : GAP_SAMPLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STS,
        S_GI2,
        S_LTS1,
        S_LTS2,
        S_GAP
    } state_t;

    state_t             state_q, state_d;
    state_t             succ_state, end_state;
    logic [IDX_W-1:0]   idx_q, idx_d, last_idx;
    logic               tvalid_q, tvalid_d;
    logic               tlast_q, tlast_d;
    logic [31:0]        tdata_q, tdata_d;
    logic [31:0]        rom_word;
    logic signed [15:0] samp_i, samp_q;
    logic [15:0]        frame_cnt_q;
    logic               handshake;

    // One STS period, Q1.15, rounded to nearest.
    function automatic logic [31:0] sts_rom(input logic [3:0] a);
        logic [31:0] w;
        w = '0;
        case (a)
            4'd0:  w = { 16'sd1507,  16'sd1507};
            4'd1:  w = {-16'sd4325,  16'sd66};
            4'd2:  w = {-16'sd426,  -16'sd2589};
            4'd3:  w = { 16'sd4686, -16'sd426};
            4'd4:  w = { 16'sd3015,  16'sd0};
            4'd5:  w = { 16'sd4686, -16'sd426};
            4'd6:  w = {-16'sd426,  -16'sd2589};
            4'd7:  w = {-16'sd4325,  16'sd66};
            4'd8:  w = { 16'sd1507,  16'sd1507};
            4'd9:  w = { 16'sd66,   -16'sd4325};
            4'd10: w = {-16'sd2589, -16'sd426};
            4'd11: w = {-16'sd426,   16'sd4686};
            4'd12: w = { 16'sd0,     16'sd3015};
            4'd13: w = {-16'sd426,   16'sd4686};
            4'd14: w = {-16'sd2589, -16'sd426};
            4'd15: w = { 16'sd66,   -16'sd4325};
            default: w = '0;
        endcase
        return w;
    endfunction

    // One LTS period, Q1.15, rounded to nearest. Entries 32..63 double as the guard interval.
    function automatic logic [31:0] lts_rom(input logic [5:0] a);
        logic [31:0] w;
        w = '0;
        case (a)
            6'd0:  w = { 16'sd5112,  16'sd0};
            6'd1:  w = {-16'sd164,  -16'sd3932};
            6'd2:  w = { 16'sd1311, -16'sd3637};
            6'd3:  w = { 16'sd3178,  16'sd2720};
            6'd4:  w = { 16'sd688,   16'sd918};
            6'd5:  w = { 16'sd1966, -16'sd2884};
            6'd6:  w = {-16'sd3768, -16'sd1802};
            6'd7:  w = {-16'sd1245, -16'sd3473};
            6'd8:  w = { 16'sd3211, -16'sd852};
            6'd9:  w = { 16'sd1737,  16'sd131};
            6'd10: w = { 16'sd33,   -16'sd3768};
            6'd11: w = {-16'sd4489, -16'sd1540};
            6'd12: w = { 16'sd786,  -16'sd1933};
            6'd13: w = { 16'sd1933, -16'sd492};
            6'd14: w = {-16'sd721,   16'sd5276};
            6'd15: w = { 16'sd3899, -16'sd131};
            6'd16: w = { 16'sd2032, -16'sd2032};
            6'd17: w = { 16'sd1212,  16'sd3211};
            6'd18: w = {-16'sd1868,  16'sd1278};
            6'd19: w = {-16'sd4293,  16'sd2130};
            6'd20: w = { 16'sd2687,  16'sd3015};
            6'd21: w = { 16'sd2294,  16'sd459};
            6'd22: w = {-16'sd1966,  16'sd2654};
            6'd23: w = {-16'sd1835, -16'sd721};
            6'd24: w = {-16'sd1147, -16'sd4948};
            6'd25: w = {-16'sd3998, -16'sd557};
            6'd26: w = {-16'sd4162, -16'sd688};
            6'd27: w = { 16'sd2458, -16'sd2425};
            6'd28: w = {-16'sd98,    16'sd1769};
            6'd29: w = {-16'sd3015,  16'sd3768};
            6'd30: w = { 16'sd3015,  16'sd3473};
            6'd31: w = { 16'sd393,   16'sd3211};
            6'd32: w = {-16'sd5112,  16'sd0};
            6'd33: w = { 16'sd393,  -16'sd3211};
            6'd34: w = { 16'sd3015, -16'sd3473};
            6'd35: w = {-16'sd3015, -16'sd3768};
            6'd36: w = {-16'sd98,   -16'sd1769};
            6'd37: w = { 16'sd2458,  16'sd2425};
            6'd38: w = {-16'sd4162,  16'sd688};
            6'd39: w = {-16'sd3998,  16'sd557};
            6'd40: w = {-16'sd1147,  16'sd4948};
            6'd41: w = {-16'sd1835,  16'sd721};
            6'd42: w = {-16'sd1966, -16'sd2654};
            6'd43: w = { 16'sd2294, -16'sd459};
            6'd44: w = { 16'sd2687, -16'sd3015};
            6'd45: w = {-16'sd4293, -16'sd2130};
            6'd46: w = {-16'sd1868, -16'sd1278};
            6'd47: w = { 16'sd1212, -16'sd3211};
            6'd48: w = { 16'sd2032,  16'sd2032};
            6'd49: w = { 16'sd3899,  16'sd131};
            6'd50: w = {-16'sd721,  -16'sd5276};
            6'd51: w = { 16'sd1933,  16'sd492};
            6'd52: w = { 16'sd786,   16'sd1933};
            6'd53: w = {-16'sd4489,  16'sd1540};
            6'd54: w = { 16'sd33,    16'sd3768};
            6'd55: w = { 16'sd1737, -16'sd131};
            6'd56: w = { 16'sd3211,  16'sd852};
            6'd57: w = {-16'sd1245,  16'sd3473};
            6'd58: w = {-16'sd3768,  16'sd1802};
            6'd59: w = { 16'sd1966,  16'sd2884};
            6'd60: w = { 16'sd688,  -16'sd918};
            6'd61: w = { 16'sd3178, -16'sd2720};
            6'd62: w = { 16'sd1311,  16'sd3637};
            6'd63: w = {-16'sd164,   16'sd3932};
            default: w = '0;
        endcase
        return w;
    endfunction

    assign handshake = tvalid_q & preamble_axis.tready;

    // State register; output registers and frame counter share the same reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tdata_q     <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            tdata_q  <= tdata_d;
            // Counted on the tlast beat, so the count is already up while the gap plays.
            if (handshake && tlast_q) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    // Next-state logic. state_q/idx_q always name the sample currently presented,
    // so nothing moves unless that sample is accepted.
    always_comb begin
        end_state  = continuous_in ? S_STS : S_IDLE;
        last_idx   = '0;
        succ_state = S_IDLE;
        case (state_q)
            S_STS:   begin last_idx = STS_LAST; succ_state = S_GI2;  end
            S_GI2:   begin last_idx = GI_LAST;  succ_state = S_LTS1; end
            S_LTS1:  begin last_idx = LTS_LAST; succ_state = S_LTS2; end
            S_LTS2:  begin
                last_idx   = LTS_LAST;
                succ_state = (GAP_SAMPLES > 0) ? S_GAP : end_state;
            end
            S_GAP:   begin last_idx = GAP_LAST; succ_state = end_state; end
            default: begin last_idx = '0;       succ_state = S_IDLE; end
        endcase

        state_d = state_q;
        idx_d   = idx_q;
        if (state_q == S_IDLE) begin
            // start_in is only looked at here, so pulses during a frame are dropped.
            if (start_in || continuous_in) begin
                state_d = S_STS;
                idx_d   = '0;
            end
        end else if (handshake) begin
            if (idx_q == last_idx) begin
                state_d = succ_state;
                idx_d   = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    // Output logic: decode the sample the FSM will present next cycle. When no
    // handshake occurs this re-decodes the current sample, which is what holds
    // the bus stable under backpressure.
    always_comb begin
        case (state_d)
            S_STS:          rom_word = sts_rom(idx_d[3:0]);
            S_GI2:          rom_word = lts_rom({1'b1, idx_d[4:0]});
            S_LTS1, S_LTS2: rom_word = lts_rom(idx_d[5:0]);
            default:        rom_word = '0;
        endcase
        // Arithmetic shift truncates toward minus infinity; negative samples stay negative.
        samp_i   = $signed(rom_word[31:16]) >>> AMP_SHIFT;
        samp_q   = $signed(rom_word[15:0])  >>> AMP_SHIFT;
        tdata_d  = {samp_i, samp_q};
        tvalid_d = (state_d != S_IDLE);
        tlast_d  = (state_d == S_LTS2) && (idx_d == LTS_LAST);
    end

    assign preamble_axis.tvalid = tvalid_q;
    assign preamble_axis.tlast  = tlast_q;
    assign preamble_axis.tdata  = tdata_q;
    assign busy_out             = (state_q != S_IDLE);
    assign frame_cnt_out        = frame_cnt_q;

endmodule

// File: tb/tb_preamble_gen.sv
// Purpose: directed checks of preamble_gen across gap/scale configurations.
// Latency: samples outputs 1 time unit after each rising edge.
// Backpressure: exercises random tready and verifies hold behaviour.
module tb_preamble_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, cont, rdy;
    int   sel;
    int   total = 0;
    int   bad   = 0;

    preamble_gen_if if_a ();
    preamble_gen_if if_b ();
    preamble_gen_if if_c ();
    assign if_a.tready = rdy;
    assign if_b.tready = rdy;
    assign if_c.tready = rdy;

    logic        busy_a, busy_b, busy_c;
    logic [15:0] cnt_a, cnt_b, cnt_c;

    // A: no gap, unscaled. B: 400-sample gap. C: no gap, scaled by 1/8.
    preamble_gen #(.GAP_SAMPLES(0), .AMP_SHIFT(0)) dut_a (
        .clk_in(clk), .rst_in(rst), .start_in(start), .continuous_in(cont),
        .preamble_axis(if_a), .busy_out(busy_a), .frame_cnt_out(cnt_a));
    preamble_gen #(.GAP_SAMPLES(400), .AMP_SHIFT(0)) dut_b (
        .clk_in(clk), .rst_in(rst), .start_in(start), .continuous_in(cont),
        .preamble_axis(if_b), .busy_out(busy_b), .frame_cnt_out(cnt_b));
    preamble_gen #(.GAP_SAMPLES(0), .AMP_SHIFT(3)) dut_c (
        .clk_in(clk), .rst_in(rst), .start_in(start), .continuous_in(cont),
        .preamble_axis(if_c), .busy_out(busy_c), .frame_cnt_out(cnt_c));

    logic        o_vld, o_last, o_busy;
    logic [31:0] o_dat;
    logic [15:0] o_cnt;

    always_comb begin
        o_vld = if_a.tvalid; o_last = if_a.tlast; o_dat = if_a.tdata; o_busy = busy_a; o_cnt = cnt_a;
        if (sel == 1) begin
            o_vld = if_b.tvalid; o_last = if_b.tlast; o_dat = if_b.tdata; o_busy = busy_b; o_cnt = cnt_b;
        end else if (sel == 2) begin
            o_vld = if_c.tvalid; o_last = if_c.tlast; o_dat = if_c.tdata; o_busy = busy_c; o_cnt = cnt_c;
        end
    end

    // Annex L short/long training values scaled by 32768 and rounded.
    localparam int STS_I [16] = '{1507, -4325, -426, 4686, 3015, 4686, -426, -4325,
                                  1507, 66, -2589, -426, 0, -426, -2589, 66};
    localparam int STS_Q [16] = '{1507, 66, -2589, -426, 0, -426, -2589, 66,
                                  1507, -4325, -426, 4686, 3015, 4686, -426, -4325};
    localparam int LTS_I [64] = '{5112, -164, 1311, 3178, 688, 1966, -3768, -1245,
                                  3211, 1737, 33, -4489, 786, 1933, -721, 3899,
                                  2032, 1212, -1868, -4293, 2687, 2294, -1966, -1835,
                                  -1147, -3998, -4162, 2458, -98, -3015, 3015, 393,
                                  -5112, 393, 3015, -3015, -98, 2458, -4162, -3998,
                                  -1147, -1835, -1966, 2294, 2687, -4293, -1868, 1212,
                                  2032, 3899, -721, 1933, 786, -4489, 33, 1737,
                                  3211, -1245, -3768, 1966, 688, 3178, 1311, -164};
    localparam int LTS_Q [64] = '{0, -3932, -3637, 2720, 918, -2884, -1802, -3473,
                                  -852, 131, -3768, -1540, -1933, -492, 5276, -131,
                                  -2032, 3211, 1278, 2130, 3015, 459, 2654, -721,
                                  -4948, -557, -688, -2425, 1769, 3768, 3473, 3211,
                                  0, -3211, -3473, -3768, -1769, 2425, 688, 557,
                                  4948, 721, -2654, -459, -3015, -2130, -1278, -3211,
                                  2032, 131, -5276, 492, 1933, 1540, 3768, -131,
                                  852, 3473, 1802, 2884, -918, -2720, 3637, 3932};

    // Expected sample n (0..319) of a frame, with arithmetic right shift sh.
    function automatic logic [31:0] exp_sample(input int n, input int sh);
        int i, q;
        if (n < 160)      begin i = STS_I[n % 16];  q = STS_Q[n % 16];  end
        else if (n < 192) begin i = LTS_I[n - 128]; q = LTS_Q[n - 128]; end
        else if (n < 256) begin i = LTS_I[n - 192]; q = LTS_Q[n - 192]; end
        else              begin i = LTS_I[n - 256]; q = LTS_Q[n - 256]; end
        i = i >>> sh;
        q = q >>> sh;
        return {16'(i), 16'(q)};
    endfunction

    logic [31:0] got_dat  [$];
    bit          got_last [$];
    logic [15:0] got_cnt  [$];
    int          cyc_used;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Accept `want` samples; start pulses when sample pulse_at is offered,
    // continuous drops when sample drop_at is offered.
    task automatic collect(input string tag, input int want, input int budget, input bit rnd,
                           input int pulse_at, input int drop_at);
        logic [31:0] h_dat;
        logic        h_last;
        bit          stalled;
        int          n, c;
        stalled = 1'b0; n = 0; c = 0; h_dat = '0; h_last = 1'b0;
        got_dat.delete(); got_last.delete(); got_cnt.delete();
        while (n < want && c < budget) begin
            if (stalled) begin
                check({tag, "_hold_vld"},  o_vld,  1);
                check({tag, "_hold_dat"},  o_dat,  h_dat);
                check({tag, "_hold_last"}, o_last, h_last);
            end
            start = (n == pulse_at);
            if (n == drop_at) cont = 1'b0;
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (o_vld && rdy) begin
                got_dat.push_back(o_dat);
                got_last.push_back(o_last);
                got_cnt.push_back(o_cnt);
                n++;
            end
            stalled = o_vld && !rdy;
            h_dat   = o_dat;
            h_last  = o_last;
            step();
            c++;
        end
        start    = 1'b0;
        rdy      = 1'b1;
        cyc_used = c;
        check({tag, "_count"}, n, want);
    endtask

    task automatic check_frame(input string tag, input int sh);
        for (int i = 0; i < 320 && i < got_dat.size(); i++) begin
            check($sformatf("%s[%0d]", tag, i), {got_last[i], got_dat[i]},
                  {(i == 319), exp_sample(i, sh)});
        end
    endtask

    initial begin
        int nl;
        int p;
        logic [48:0] e;
        rst = 1'b1; start = 1'b0; cont = 1'b0; rdy = 1'b1; sel = 0;
        repeat (3) step();
        check("rst_vld",  o_vld,  0);
        check("rst_last", o_last, 0);
        check("rst_dat",  o_dat,  0);
        check("rst_busy", o_busy, 0);
        check("rst_cnt",  o_cnt,  0);
        rst = 1'b0;
        step();
        check("idle_vld", o_vld, 0);

        // Single frame, no gap, tready high.
        pulse_start();
        check("t1_lat_vld",  o_vld,  1);
        check("t1_lat_dat",  o_dat,  32'h05E3_05E3);
        check("t1_lat_busy", o_busy, 1);
        collect("t1", 320, 400, 1'b0, -1, -1);
        check("t1_cycles", cyc_used, 320);
        check("t1_end_vld",  o_vld,  0);
        check("t1_end_busy", o_busy, 0);
        check("t1_end_cnt",  o_cnt,  1);
        if (got_dat.size() == 320) begin
            check("t1_s0",   got_dat[0],   32'h05E3_05E3);
            check("t1_s16",  got_dat[16],  32'h05E3_05E3);
            check("t1_s160", got_dat[160], 32'hEC08_0000);
            check("t1_s192", got_dat[192], 32'h13F8_0000);
            check("t1_s256", got_dat[256], 32'h13F8_0000);
        end
        check_frame("t1_smp", 0);

        // Random backpressure: same sequence, held bus on stalls.
        pulse_start();
        collect("t2", 320, 3000, 1'b1, -1, -1);
        check_frame("t2_smp", 0);
        check("t2_end_vld", o_vld, 0);
        check("t2_end_cnt", o_cnt, 2);

        // start during an active frame is ignored.
        pulse_start();
        collect("t3", 320, 400, 1'b0, 100, -1);
        check_frame("t3_smp", 0);
        repeat (5) step();
        check("t3_no_2nd_vld", o_vld,  0);
        check("t3_no_2nd_bsy", o_busy, 0);
        check("t3_cnt",        o_cnt,  3);

        // Reset at sample 200, then a fresh frame.
        pulse_start();
        collect("t4a", 200, 300, 1'b0, -1, -1);
        nl = 0;
        foreach (got_last[i]) nl += int'(got_last[i]);
        check("t4_no_partial_last", nl, 0);
        rst = 1'b1;
        step();
        check("t4_rst_vld",  o_vld,  0);
        check("t4_rst_last", o_last, 0);
        check("t4_rst_dat",  o_dat,  0);
        check("t4_rst_busy", o_busy, 0);
        check("t4_rst_cnt",  o_cnt,  0);
        rst = 1'b0;
        pulse_start();
        check("t4_restart_dat", o_dat, 32'h05E3_05E3);
        collect("t4b", 320, 400, 1'b0, -1, -1);
        check_frame("t4_smp", 0);
        check("t4_cnt", o_cnt, 1);

        // Continuous with 400-sample gap, three frames.
        sel = 1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        cont = 1'b1;
        step();
        check("t5_first_vld", o_vld, 1);
        check("t5_first_dat", o_dat, 32'h05E3_05E3);
        collect("t5", 2160, 2300, 1'b0, -1, 1540);
        check("t5_cycles", cyc_used, 2160);
        for (int i = 0; i < got_dat.size(); i++) begin
            p = i % 720;
            e = {16'(i / 720 + ((p >= 320) ? 1 : 0)), (p == 319),
                 (p < 320) ? exp_sample(p, 0) : 32'h0};
            check($sformatf("t5_smp[%0d]", i), {got_cnt[i], got_last[i], got_dat[i]}, e);
        end
        check("t5_end_vld",  o_vld,  0);
        check("t5_end_busy", o_busy, 0);
        check("t5_end_cnt",  o_cnt,  3);

        // Reset and start in the same cycle: reset wins. Then scaled frame.
        sel = 2;
        cont = 1'b0;
        rst = 1'b1; start = 1'b1;
        step();
        rst = 1'b0; start = 1'b0;
        check("t6_rst_start_vld", o_vld, 0);
        step();
        check("t6_still_idle", o_vld, 0);
        pulse_start();
        collect("t6", 320, 400, 1'b0, -1, -1);
        if (got_dat.size() == 320) begin
            check("t6_s0",   got_dat[0],   32'h00BC_00BC);
            check("t6_s1",   got_dat[1],   32'hFDE3_0008);
            check("t6_s160", got_dat[160], 32'hFD81_0000);
            check("t6_s164", got_dat[164], 32'hFFF3_FF22);
        end
        check_frame("t6_smp", 3);
        check("t6_cnt", o_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
